// File: rtl/piso_siso_univ_shreg.sv
// piso_siso_univ_shreg
// Parametrised universal shift register: DEPTH stages of WIDTH bits each.
// Supports hold, shift-up, shift-down, parallel load and a synchronous clear.
// Serial taps at both ends, a flat parallel view of every stage, and a
// saturating fill counter with a full flag so downstream logic knows when
// the serial output carries data that was really shifted in.

module piso_siso_univ_shreg #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         si,
  input  logic [DEPTH*WIDTH-1:0]   pin,
  output logic [WIDTH-1:0]         so_hi,
  output logic [WIDTH-1:0]         so_lo,
  output logic [DEPTH*WIDTH-1:0]   pout,
  output logic [CW-1:0]            count,
  output logic                     full
);

  // Operating modes, encoded to match the mode input directly.
  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_UP    = 2'b01,
    MODE_DOWN  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  // Count value that means "every stage holds shifted-in or loaded data".
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Stage storage and the fill counter.
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Decoded control for the current edge.
  mode_e modeSel;
  logic  doShift;
  logic  countSat;

  assign modeSel  = mode_e'(mode);
  assign doShift  = en && ((modeSel == MODE_UP) || (modeSel == MODE_DOWN));
  assign countSat = (count_q == DEPTH_C);

  // Next-state for the stages: clear beats any enabled mode, otherwise hold.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_d[i] = '0;
      end
    end else if (en) begin
      unique case (modeSel)
        MODE_UP: begin
          stage_d[0] = si;
          for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
          end
        end
        MODE_DOWN: begin
          stage_d[DEPTH-1] = si;
          for (int i = 0; i < DEPTH - 1; i++) begin
            stage_d[i] = stage_q[i+1];
          end
        end
        MODE_LOAD: begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = pin[i*WIDTH +: WIDTH];
          end
        end
        default: begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
          end
        end
      endcase
    end
  end

  // Next-state for the fill counter: a shift in either direction adds one
  // valid stage until the register is full, a load fills it outright.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (modeSel == MODE_LOAD)) begin
      count_d = DEPTH_C;
    end else if (doShift && !countSat) begin
      count_d = count_q + CW'(1);
    end
  end

  // Stage registers; reset discards any partially shifted data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // Fill counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flatten the stages onto the parallel output, stage i in lane i.
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : gPout
      assign pout[g*WIDTH +: WIDTH] = stage_q[g];
    end
  endgenerate

  // Serial taps and status are read straight from the registers.
  assign so_hi = stage_q[DEPTH-1];
  assign so_lo = stage_q[0];
  assign count = count_q;
  assign full  = countSat;

endmodule

// File: tb/tb_piso_siso_univ_shreg.sv
// tb_piso_siso_univ_shreg
// Directed checks on the default 1x4 register and a modelled random run on a
// 2x8 instance.

module tb_piso_siso_univ_shreg;

  logic clk;
  logic rst_n;

  // Default-size instance signals.
  logic       en, clr;
  logic [1:0] mode;
  logic [0:0] si;
  logic [3:0] pin;
  logic [0:0] soHi, soLo;
  logic [3:0] pout;
  logic [2:0] count;
  logic       full;

  // Wide instance signals.
  logic        en2, clr2;
  logic [1:0]  mode2;
  logic [1:0]  si2;
  logic [15:0] pin2;
  logic [1:0]  soHi2, soLo2;
  logic [15:0] pout2;
  logic [3:0]  count2;
  logic        full2;

  int totalChecks;
  int badChecks;

  piso_siso_univ_shreg #(.WIDTH(1), .DEPTH(4)) dutSmall (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .si(si),
    .pin(pin), .so_hi(soHi), .so_lo(soLo), .pout(pout), .count(count),
    .full(full)
  );

  piso_siso_univ_shreg #(.WIDTH(2), .DEPTH(8)) dutWide (
    .clk(clk), .rst_n(rst_n), .en(en2), .clr(clr2), .mode(mode2), .si(si2),
    .pin(pin2), .so_hi(soHi2), .so_lo(soLo2), .pout(pout2), .count(count2),
    .full(full2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] simulation timed out");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the small instance, take one edge, then settle past it.
  task automatic applyStimulus(input logic e, input logic c, input logic [1:0] m,
                               input logic s, input logic [3:0] p);
    en = e; clr = c; mode = m; si = s; pin = p;
    @(posedge clk);
    #1;
  endtask

  task automatic checkSmall(input string tag, input logic [3:0] expPout,
                            input logic [2:0] expCount);
    checkOutput({tag, ".pout"}, 32'(pout), 32'(expPout));
    checkOutput({tag, ".count"}, 32'(count), 32'(expCount));
    checkOutput({tag, ".full"}, 32'(full), 32'(expCount == 3'd4));
  endtask

  // Directed vectors: shift-in sequence and expected pout/count after each edge.
  logic [3:0] upSi;
  logic [3:0] upPout [5];
  logic [2:0] upCount [5];

  // Reference state for the wide instance.
  logic [1:0]  mq [8];
  int          mcnt;
  logic [15:0] expPout2;
  bit          hitMode [4];
  bit          hitClr, hitSat;

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    rst_n = 1'b0;
    en = 0; clr = 0; mode = 2'b00; si = 0; pin = '0;
    en2 = 0; clr2 = 0; mode2 = 2'b00; si2 = '0; pin2 = '0;
    #12;
    checkSmall("reset", 4'h0, 3'd0);
    checkOutput("reset.wideCount", 32'(count2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: reset lands between edges in the middle of a shift sequence.
    applyStimulus(1, 0, 2'b01, 1, 4'h0);
    applyStimulus(1, 0, 2'b01, 1, 4'h0);
    checkSmall("preReset", 4'b0011, 3'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkSmall("asyncReset", 4'h0, 3'd0);
    #2;
    rst_n = 1'b1;

    // Test 2: shift-up 1,0,1,1 then one more 0 to hit saturation.
    upSi = 4'b1101;
    upPout[0] = 4'b0001; upCount[0] = 3'd1;
    upPout[1] = 4'b0010; upCount[1] = 3'd2;
    upPout[2] = 4'b0101; upCount[2] = 3'd3;
    upPout[3] = 4'b1011; upCount[3] = 3'd4;
    upPout[4] = 4'b0110; upCount[4] = 3'd4;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 2'b01, upSi[i], 4'h0);
      checkSmall($sformatf("shiftUp%0d", i), upPout[i], upCount[i]);
    end
    checkOutput("shiftUp.soHi", 32'(soHi), 32'd1);
    applyStimulus(1, 0, 2'b01, 0, 4'h0);
    checkSmall("shiftUpSat", upPout[4], upCount[4]);

    // Test 3: load then one shift-down.
    applyStimulus(1, 0, 2'b11, 0, 4'hA);
    checkSmall("load", 4'hA, 3'd4);
    applyStimulus(1, 0, 2'b10, 0, 4'h0);
    checkSmall("shiftDown", 4'b0101, 3'd4);
    checkOutput("shiftDown.soLo", 32'(soLo), 32'd1);

    // Test 4: hold via en=0, then via mode=00.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 2'b01, i[0], 4'hF);
      checkSmall($sformatf("holdEn%0d", i), 4'b0101, 3'd4);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 2'b00, i[0], 4'hF);
      checkSmall($sformatf("holdMode%0d", i), 4'b0101, 3'd4);
    end

    // Test 5: clear beats load on the same edge.
    applyStimulus(1, 1, 2'b11, 1, 4'hF);
    checkSmall("clrWins", 4'h0, 3'd0);

    // Count climbs from zero in either direction, and across a direction change.
    applyStimulus(1, 0, 2'b10, 1, 4'h0);
    checkSmall("downFromEmpty", 4'b1000, 3'd1);
    checkOutput("downFromEmpty.soHi", 32'(soHi), 32'd1);
    applyStimulus(1, 0, 2'b01, 0, 4'h0);
    checkSmall("dirChange", 4'b0000, 3'd2);

    // Test 6: random run of the 2x8 instance against a reference model.
    en = 0; clr = 0;
    for (int i = 0; i < 8; i++) mq[i] = '0;
    mcnt = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      en2   = ($urandom_range(0, 9) != 0);
      clr2  = ($urandom_range(0, 11) == 0);
      mode2 = 2'($urandom_range(0, 3));
      si2   = 2'($urandom_range(0, 3));
      pin2  = 16'($urandom);
      @(posedge clk);
      if (clr2) begin
        hitClr = 1;
        for (int i = 0; i < 8; i++) mq[i] = '0;
        mcnt = 0;
      end else if (en2) begin
        hitMode[mode2] = 1;
        case (mode2)
          2'b01: begin
            for (int i = 7; i > 0; i--) mq[i] = mq[i-1];
            mq[0] = si2;
            if (mcnt == 8) hitSat = 1; else mcnt++;
          end
          2'b10: begin
            for (int i = 0; i < 7; i++) mq[i] = mq[i+1];
            mq[7] = si2;
            if (mcnt == 8) hitSat = 1; else mcnt++;
          end
          2'b11: begin
            for (int i = 0; i < 8; i++) mq[i] = pin2[i*2 +: 2];
            mcnt = 8;
          end
          default: ;
        endcase
      end
      #1;
      for (int i = 0; i < 8; i++) expPout2[i*2 +: 2] = mq[i];
      checkOutput($sformatf("rand%0d.pout", cyc), 32'(pout2), 32'(expPout2));
      checkOutput($sformatf("rand%0d.soHi", cyc), 32'(soHi2), 32'(mq[7]));
      checkOutput($sformatf("rand%0d.soLo", cyc), 32'(soLo2), 32'(mq[0]));
      checkOutput($sformatf("rand%0d.count", cyc), 32'(count2), 32'(mcnt));
      checkOutput($sformatf("rand%0d.full", cyc), 32'(full2), 32'(mcnt == 8));
    end
    for (int m = 0; m < 4; m++) begin
      checkOutput($sformatf("coverMode%0d", m), 32'(hitMode[m]), 32'd1);
    end
    checkOutput("coverClr", 32'(hitClr), 32'd1);
    checkOutput("coverSat", 32'(hitSat), 32'd1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
